// File: rtl/alsu_ctrl.sv
// ALSU controller: one-shot logic/arith ops, bit-serial shifts.
// Ports: in_valid/in_ready request, out_valid/out_ready result.
module alsu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             invalid,
  output logic             busy
);

  localparam int LW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LW-1:0] CNT_ONE = LW'(1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             inv_q, inv_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_inv;
  logic [LW-1:0]    amt;
  logic             is_sh;
  logic [WIDTH-1:0] step_acc;
  logic             step_out;

  assign amt   = B[LW-1:0];
  assign is_sh = opcode[2] && (opcode != 3'b111);

  // Single-cycle path, also covers shifts by zero.
  always_comb begin
    sum_w   = {1'b0, A} + {1'b0, B}
            + {{WIDTH{1'b0}}, cin};
    dif_w   = {1'b0, A} - {1'b0, B}
            - {{WIDTH{1'b0}}, cin};
    alu_r   = A;
    alu_c   = 1'b0;
    alu_inv = 1'b0;
    unique case (opcode)
      3'b000: alu_r = A & B;
      3'b001: alu_r = A ^ B;
      3'b010: begin
        alu_r = sum_w[WIDTH-1:0];
        alu_c = sum_w[WIDTH];
      end
      // MSB of the extended difference is the borrow.
      3'b011: begin
        alu_r = dif_w[WIDTH-1:0];
        alu_c = dif_w[WIDTH];
      end
      3'b100,
      3'b101,
      3'b110: alu_r = A;
      3'b111: begin
        alu_r   = '0;
        alu_inv = 1'b1;
      end
      default: alu_r = A;
    endcase
  end

  // One bit of shift per EXEC cycle.
  always_comb begin
    step_out = acc_q[WIDTH-1];
    step_acc = {acc_q[WIDTH-2:0], 1'b0};
    unique case (op_q)
      3'b101: begin
        step_out = acc_q[0];
        step_acc = {1'b0, acc_q[WIDTH-1:1]};
      end
      3'b110: begin
        step_acc = {acc_q[WIDTH-2:0],
                    acc_q[WIDTH-1]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    c_d     = c_q;
    z_d     = z_q;
    inv_d   = inv_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = opcode;
          a_d   = A;
          b_d   = B;
          cin_d = cin;
          if (is_sh && (amt != '0)) begin
            state_d = S_EXEC;
            acc_d   = A;
            cnt_d   = amt;
          end else begin
            state_d = S_DONE;
            res_d   = alu_r;
            c_d     = alu_c;
            z_d     = (alu_r == '0);
            inv_d   = alu_inv;
          end
        end
      end
      S_EXEC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          res_d   = step_acc;
          c_d     = step_out;
          z_d     = (step_acc == '0);
          inv_d   = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      c_q     <= c_d;
      z_q     <= z_d;
      inv_q   <= inv_d;
    end
  end

  // Captured operands are kept for debug visibility only.
  logic unused_cap;
  assign unused_cap = ^{a_q, b_q, cin_q};

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_EXEC);
  assign result    = res_q;
  assign carry     = c_q;
  assign zero      = z_q;
  assign invalid   = inv_q;

endmodule

// File: doc/alsu_ctrl.md
ALSU_CTRL -- requirements
Module: alsu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand/result width; legal values 4..32, powers of two.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, the request is present.
REQ-005 SHALL have port in_ready, output, 1, the controller can accept a request.
REQ-006 SHALL have port opcode, input, 3, the operation select.
REQ-007 SHALL have ports A and B, input, WIDTH each, the operands.
REQ-008 SHALL have port cin, input, 1, the carry-in for ADD/SUB.
REQ-009 SHALL have port out_valid, output, 1, the result is presented.
REQ-010 SHALL have port out_ready, input, 1, the consumer takes the result.
REQ-011 SHALL have port result, output, WIDTH, the registered result.
REQ-012 SHALL have ports carry, zero and invalid, output, 1 each, the registered flags.
REQ-013 SHALL have port busy, output, 1, high while in EXEC.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL capture opcode, A, B and cin into internal registers on a rising edge with in_valid && in_ready (accept edge).
REQ-016 Opcodes: 000 AND; 001 XOR; 010 ADD = A+B+cin, carry = bit WIDTH; 011 SUB = A-B-cin, carry = borrow; 100 SHL; 101 SHR (logical); 110 ROL; 111 invalid.
REQ-017 For 000-011 and 111, SHALL go IDLE->DONE on the accept edge, with result/flags valid in the next cycle (latency 1).
REQ-018 For 100-110, shift amount N = B[log2(WIDTH)-1:0]; if N==0, IDLE->DONE with result=A (latency 1).
REQ-019 For 100-110 with N>0, SHALL go IDLE->EXEC, load the accumulator with A and the counter with N, then shift the accumulator by exactly 1 bit per EXEC cycle and decrement the counter.
REQ-020 SHALL go EXEC->DONE on the edge where the counter goes 1->0; out_valid is first high N+1 cycles after the accept edge and busy is high for exactly N cycles.
REQ-021 SHL/SHR SHALL shift in 0; ROL SHALL feed the MSB into the LSB; carry SHALL equal the last bit shifted out (ROL: last bit rotated); carry = 0 for N==0 and for logic ops.
REQ-022 zero SHALL be 1 iff the final result == 0; it is evaluated on the result, not the operands.
REQ-023 Opcode 111 SHALL give result=0, invalid=1, carry=0 and zero=1; invalid = 0 for all other opcodes.
REQ-024 DONE SHALL go to IDLE on an edge with out_ready=1; while out_ready=0, result and flags SHALL stay stable and in_ready stays 0.
REQ-025 Requests with in_valid=1 while in_ready=0 SHALL be ignored and have no effect on state.
REQ-026 Results/flags SHALL hold their last values in IDLE; a new operation only overwrites them on the edge entering DONE.
REQ-027 No back-to-back acceptance: the minimum issue interval is 2 cycles (DONE->IDLE->accept).

Reset
REQ-028 rst=0 SHALL immediately, without a clock, force state=IDLE; result, carry, zero, invalid, busy, counter, accumulator and captured operands = 0; out_valid=0 and in_ready=1.
REQ-029 Reset during EXEC or DONE SHALL discard the in-flight operation; no out_valid pulse may follow release.
REQ-030 After rst rises, the first accept SHALL be possible on the first rising edge.

Verification (WIDTH=8)
REQ-031 ADD with A=0xF0, B=0x20, cin=1 -> one cycle after accept, out_valid=1, result=0x11, carry=1, zero=0.
REQ-032 SHL with A=0x81, B=0x03 -> busy high for 3 cycles; out_valid at accept+4; result=0x08, carry=0 (last bit out was 0).
REQ-033 ROL with A=0x81, B=0x00 -> out_valid at accept+1, result=0x81, carry=0; ROL with B=0x01 -> result=0x03, carry=1.
REQ-034 SUB with A=B=0x55, cin=0 held with out_ready=0 for 5 cycles -> result=0x00 and zero=1, stable all 5 cycles, in_ready=0; a second in_valid pulse is ignored; out_ready=1 -> IDLE next cycle.
REQ-035 rst=0 asserted asynchronously in the 2nd EXEC cycle of SHR with A=0xF0, B=7 -> outputs zero before the next edge; after release, in_ready=1 and no out_valid occurs.
REQ-036 opcode=111 with A=0xFF -> out_valid at accept+1, result=0x00, invalid=1, zero=1; the next valid ADD clears invalid.
